// File: rtl/mac15_scheduler.sv
// Round-robin window scheduler sharing one accumulate15 path between
// NUM_REQ requesters, with in-order tag routing of returned results.
module mac15_scheduler #(
  parameter int NUM_REQ   = 3,
  parameter int DATA_W    = 32,
  parameter int TAP_COUNT = 15,
  parameter int TAG_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        in_valid,
  input  logic [NUM_REQ*DATA_W-1:0] in_data,
  output logic [NUM_REQ-1:0]        in_ready,
  output logic                      mult_valid,
  output logic [DATA_W-1:0]         mult_data,
  input  logic                      acc_valid,
  input  logic [DATA_W-1:0]         acc_data,
  output logic [NUM_REQ-1:0]        res_valid,
  output logic [DATA_W-1:0]         res_data,
  output logic                      busy,
  output logic                      err_orphan
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TAP_COUNT + 1);
  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int OCC_W = $clog2(TAG_DEPTH + 1);

  typedef enum logic {IDLE, BURST} state_e;

  state_e              state_q;
  logic [IDX_W-1:0]    grant_q;
  logic [IDX_W-1:0]    rr_ptr_q;
  logic [CNT_W-1:0]    beat_cnt_q;
  logic [IDX_W-1:0]    tag_q [TAG_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q;
  logic [PTR_W-1:0]    rd_ptr_q;
  logic [OCC_W-1:0]    occ_q;
  logic [OCC_W-1:0]    occ_d;
  logic                mult_valid_q;
  logic [DATA_W-1:0]   mult_data_q;
  logic [NUM_REQ-1:0]  res_valid_q;
  logic [DATA_W-1:0]   res_data_q;
  logic                err_q;

  logic [IDX_W-1:0]    sel_d;
  logic [IDX_W-1:0]    rr_next;
  logic                full;
  logic                empty;
  logic                accept;
  logic                push;
  logic                pop;
  logic                last_beat;

  assign full      = (occ_q == OCC_W'(TAG_DEPTH));
  assign empty     = (occ_q == '0);
  assign accept    = (state_q == BURST) && in_valid[grant_q];
  assign push      = (state_q == IDLE) && (|in_valid) && !full;
  assign pop       = acc_valid && !empty;
  assign last_beat = (beat_cnt_q == CNT_W'(TAP_COUNT - 1));
  assign rr_next   = (grant_q == IDX_W'(NUM_REQ - 1)) ?
                     '0 : grant_q + 1'b1;

  assign in_ready = (state_q == BURST) ?
                    (NUM_REQ'(1) << grant_q) : '0;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    logic             found;
    int               cand;
    logic [IDX_W-1:0] cand_w;
    sel_d  = rr_ptr_q;
    found  = 1'b0;
    cand   = 0;
    cand_w = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_w = IDX_W'(cand);
      if (!found && in_valid[cand_w]) begin
        found = 1'b1;
        sel_d = cand_w;
      end
    end
  end

  always_comb begin
    occ_d = occ_q;
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      rr_ptr_q     <= '0;
      beat_cnt_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      mult_valid_q <= 1'b0;
      mult_data_q  <= '0;
      res_valid_q  <= '0;
      res_data_q   <= '0;
      err_q        <= 1'b0;
      for (int i = 0; i < TAG_DEPTH; i++) tag_q[i] <= '0;
    end else begin
      mult_valid_q <= accept;
      if (accept)
        mult_data_q <= in_data[grant_q*DATA_W +: DATA_W];

      res_valid_q <= pop ? (NUM_REQ'(1) << tag_q[rd_ptr_q]) : '0;
      if (pop) begin
        res_data_q <= acc_data;
        rd_ptr_q   <= rd_ptr_q + 1'b1;
      end
      if (acc_valid && empty) err_q <= 1'b1;

      if (push) begin
        tag_q[wr_ptr_q] <= sel_d;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      occ_q <= occ_d;

      unique case (state_q)
        IDLE: begin
          if (push) begin
            grant_q    <= sel_d;
            beat_cnt_q <= '0;
            state_q    <= BURST;
          end
        end
        BURST: begin
          if (accept) begin
            if (last_beat) begin
              state_q    <= IDLE;
              rr_ptr_q   <= rr_next;
              beat_cnt_q <= '0;
            end else begin
              beat_cnt_q <= beat_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mult_valid = mult_valid_q;
  assign mult_data  = mult_data_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign busy       = (state_q == BURST) || !empty;
  assign err_orphan = err_q;

endmodule

// File: tb/tb_mac15_scheduler.sv
// Bench for mac15_scheduler: vector table, corner sequences and a
// randomized run against a queue-based reference model.
module tb_mac15_scheduler;

  localparam int N = 3;
  localparam int W = 32;
  localparam int T = 15;
  localparam int D = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           mult_valid;
  logic [W-1:0]   mult_data;
  logic           acc_valid;
  logic [W-1:0]   acc_data;
  logic [N-1:0]   res_valid;
  logic [W-1:0]   res_data;
  logic           busy;
  logic           err_orphan;

  mac15_scheduler #(
    .NUM_REQ(N), .DATA_W(W), .TAP_COUNT(T), .TAG_DEPTH(D)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mult_valid(mult_valid), .mult_data(mult_data),
    .acc_valid(acc_valid), .acc_data(acc_data),
    .res_valid(res_valid), .res_data(res_data),
    .busy(busy), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [W-1:0] mq[$];
  always @(negedge clk) if (mult_valid === 1'b1) mq.push_back(mult_data);

  task automatic do_reset();
    in_valid  = '0;
    in_data   = '0;
    acc_valid = 1'b0;
    acc_data  = '0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drive_window(input int req, input logic [W-1:0] d0,
                              input logic [W-1:0] d1, input int n0,
                              input int gap);
    int sent = 0;
    int cyc  = 0;
    int g    = 0;
    while (sent < T && cyc < 300) begin
      @(negedge clk);
      if (sent == n0 && g < gap) begin
        in_valid[req] = 1'b0;
        g++;
      end else begin
        in_valid[req] = 1'b1;
        in_data[req*W +: W] = (sent < n0) ? d0 : d1;
      end
      #1;
      if (!in_valid[req]) check("ready_held_in_gap", in_ready[req], 1);
      check("foreign_ready", in_ready & ~(N'(1) << req), 0);
      if (in_valid[req] && in_ready[req]) sent++;
      cyc++;
    end
    check("window_beats", sent, T);
    @(negedge clk);
    in_valid[req] = 1'b0;
  endtask

  task automatic pulse_acc(input logic [W-1:0] v);
    @(negedge clk);
    acc_valid = 1'b1;
    acc_data  = v;
    @(negedge clk);
    acc_valid = 1'b0;
    #1;
  endtask

  typedef struct {
    int           req;
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    int           n0;
    int           gap;
    logic [W-1:0] acc;
    logic [N-1:0] rv;
  } vec_t;

  vec_t tbl[5];

  // Reference model state
  bit           m_burst;
  int           m_owner, m_beats, m_rr;
  int           m_tags[$];
  bit           m_err;
  logic         m_mv;
  logic [W-1:0] m_md, m_rd;
  logic [N-1:0] m_rv;

  initial begin
    int order[$];
    int exp_order[4];
    logic [N-1:0] prev;
    int bad;
    int sent;
    int acc_p;

    tbl[0] = '{0, 32'd1, 32'd1, 15, 0, 32'd15, 3'b001};
    tbl[1] = '{1, 32'd2, 32'd3, 10, 6, 32'd35, 3'b010};
    tbl[2] = '{2, 32'd7, 32'd7, 15, 0, 32'd105, 3'b100};
    tbl[3] = '{0, 32'hFFFF_FFFF, 32'd5, 3, 2, 32'h1234, 3'b001};
    tbl[4] = '{2, 32'hA5, 32'h5A, 8, 1, 32'hDEAD_BEEF, 3'b100};

    in_valid  = '0;
    in_data   = '0;
    acc_valid = 1'b0;
    acc_data  = '0;
    rst_n     = 1'b0;
    #12;
    check("rst_mult_valid", mult_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_orphan, 0);
    do_reset();

    for (int t = 0; t < 5; t++) begin
      mq.delete();
      drive_window(tbl[t].req, tbl[t].d0, tbl[t].d1, tbl[t].n0, tbl[t].gap);
      repeat (2) @(negedge clk);
      check("tbl_beat_count", mq.size(), T);
      bad = 0;
      for (int i = 0; i < mq.size(); i++)
        if (mq[i] !== ((i < tbl[t].n0) ? tbl[t].d0 : tbl[t].d1)) bad++;
      check("tbl_beat_data", bad, 0);
      check("tbl_busy_pending", busy, 1);
      pulse_acc(tbl[t].acc);
      check("tbl_res_valid", res_valid, tbl[t].rv);
      check("tbl_res_data", res_data, tbl[t].acc);
      @(negedge clk);
      #1;
      check("tbl_res_single", res_valid, 0);
      check("tbl_busy_idle", busy, 0);
    end

    // Contention: grant order and tag FIFO full stall
    mq.delete();
    @(negedge clk);
    in_valid = '1;
    in_data  = {32'd30, 32'd20, 32'd10};
    prev = '0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      #1;
      if (in_ready != 0 && prev == 0)
        for (int r = 0; r < N; r++) if (in_ready[r]) order.push_back(r);
      prev = in_ready;
    end
    exp_order = '{0, 1, 2, 0};
    check("rr_windows", order.size(), 4);
    for (int i = 0; i < 4 && i < order.size(); i++)
      check("rr_order", order[i], exp_order[i]);
    check("full_no_ready", in_ready, 0);
    check("full_busy", busy, 1);
    check("rr_beat_count", mq.size(), 4 * T);
    bad = 0;
    for (int i = 0; i < mq.size(); i++)
      if (mq[i] !== W'((exp_order[(i / T) % 4] + 1) * 10)) bad++;
    check("rr_beat_data", bad, 0);

    pulse_acc(32'd100);
    check("rr_res0_valid", res_valid, 3'b001);
    check("rr_res0_data", res_data, 100);
    @(negedge clk);
    #1;
    check("resume_grant", in_ready, 3'b010);
    in_valid = '0;
    drive_window(1, 32'd20, 32'd20, 15, 0);
    repeat (2) @(negedge clk);
    check("resume_beats", mq.size(), 5 * T);
    pulse_acc(32'd101);
    check("rr_res1", res_valid, 3'b010);
    pulse_acc(32'd102);
    check("rr_res2", res_valid, 3'b100);
    check("rr_res2_data", res_data, 102);
    pulse_acc(32'd103);
    check("rr_res3", res_valid, 3'b001);
    pulse_acc(32'd104);
    check("rr_res4", res_valid, 3'b010);
    @(negedge clk);
    #1;
    check("drained_busy", busy, 0);
    check("no_orphan_yet", err_orphan, 0);

    // Orphan result
    pulse_acc(32'd55);
    check("orphan_err", err_orphan, 1);
    check("orphan_no_res", res_valid, 0);
    repeat (5) @(negedge clk);
    check("orphan_sticky", err_orphan, 1);

    // Reset after the 7th beat of a window
    sent = 0;
    for (int c = 0; c < 100 && sent < 7; c++) begin
      @(negedge clk);
      in_valid[2] = 1'b1;
      in_data[2*W +: W] = 32'd9;
      #1;
      if (in_ready[2]) sent++;
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_mult_valid", mult_valid, 0);
    check("midrst_mult_data", mult_data, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_busy", busy, 0);
    check("midrst_err", err_orphan, 0);
    @(negedge clk);
    in_valid = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    drive_window(2, 32'd4, 32'd4, 15, 0);
    repeat (2) @(negedge clk);
    check("post_rst_beats", mq.size(), T);
    pulse_acc(32'd60);
    check("post_rst_res", res_valid, 3'b100);
    check("post_rst_data", res_data, 60);

    // Randomized traffic against the reference model
    do_reset();
    m_burst = 0; m_owner = 0; m_beats = 0; m_rr = 0;
    m_tags.delete();
    m_err = 0; m_mv = 0; m_md = '0; m_rd = '0; m_rv = '0;
    for (int c = 0; c < 4000; c++) begin
      bit pop;
      bit acc;
      acc_p = (c < 2000) ? 40 : 6;
      @(negedge clk);
      for (int r = 0; r < N; r++) begin
        in_valid[r] = ($urandom_range(0, 9) < 7);
        in_data[r*W +: W] = $urandom;
      end
      acc_valid = ($urandom_range(0, acc_p - 1) == 0);
      acc_data  = $urandom;
      #1;
      check("rnd_in_ready", in_ready, m_burst ? (N'(1) << m_owner) : 0);
      check("rnd_busy", busy, m_burst || m_tags.size() > 0);
      check("rnd_mult_valid", mult_valid, m_mv);
      check("rnd_mult_data", mult_data, m_md);
      check("rnd_res_valid", res_valid, m_rv);
      check("rnd_res_data", res_data, m_rd);
      check("rnd_err", err_orphan, m_err);

      pop = acc_valid && m_tags.size() > 0;
      m_rv = pop ? (N'(1) << m_tags[0]) : '0;
      if (pop) m_rd = acc_data;
      if (acc_valid && m_tags.size() == 0) m_err = 1;
      acc = m_burst && in_valid[m_owner];
      m_mv = acc;
      if (acc) m_md = in_data[m_owner*W +: W];
      if (!m_burst) begin
        if (in_valid != 0 && m_tags.size() < D) begin
          for (int k = N - 1; k >= 0; k--)
            if (in_valid[(m_rr + k) % N]) m_owner = (m_rr + k) % N;
          m_tags.push_back(m_owner);
          m_burst = 1;
          m_beats = 0;
        end
      end else if (acc) begin
        m_beats++;
        if (m_beats == T) begin
          m_burst = 0;
          m_rr = (m_owner + 1) % N;
        end
      end
      if (pop) void'(m_tags.pop_front());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
